// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Every output is registered from the next coordinate, so all of them line up with pix_x/pix_y.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 11,
   parameter int FCW      = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pix_en,
   output logic           hsync,
   output logic           vsync,
   output logic           draw,
   output logic [CW-1:0]  pix_x,
   output logic [CW-1:0]  pix_y,
   output logic           line_start,
   output logic           frame_start,
   output logic [FCW-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_HI  = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_HI  = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [CW-1:0]  x_q, x_d;
   logic [CW-1:0]  y_q, y_d;
   logic [FCW-1:0] fc_q, fc_d;
   logic           hs_q, hs_d;
   logic           vs_q, vs_d;
   logic           draw_q, draw_d;
   logic           ls_q, fs_q;
   logic           x_wrap, y_wrap;

   always_comb begin
      x_wrap = (x_q == X_LAST);
      y_wrap = (y_q == Y_LAST);
      x_d    = x_wrap ? '0 : x_q + CW'(1);
      y_d    = y_q;
      fc_d   = fc_q;
      if (x_wrap) begin
         y_d = y_wrap ? '0 : y_q + CW'(1);
      end
      if (x_wrap && y_wrap) begin
         fc_d = fc_q + FCW'(1);
      end
      // Decode from the next coordinate so sync/draw land on the same edge.
      hs_d   = ((x_d >= HS_LO) && (x_d < HS_HI)) ? HS_POL : ~HS_POL;
      vs_d   = ((y_d >= VS_LO) && (y_d < VS_HI)) ? VS_POL : ~VS_POL;
      draw_d = (x_d < H_ACT) && (y_d < V_ACT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q    <= X_LAST;
         y_q    <= Y_LAST;
         fc_q   <= '0;
         hs_q   <= ~HS_POL;
         vs_q   <= ~VS_POL;
         draw_q <= 1'b0;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
      end else begin
         ls_q <= 1'b0;
         fs_q <= 1'b0;
         if (pix_en) begin
            x_q    <= x_d;
            y_q    <= y_d;
            fc_q   <= fc_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            draw_q <= draw_d;
            ls_q   <= (x_d == '0);
            fs_q   <= (x_d == '0) && (y_d == '0);
         end
      end
   end

   assign pix_x       = x_q;
   assign pix_y       = y_q;
   assign frame_cnt   = fc_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign draw        = draw_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule
